stump_memory_responder: RTL and testbench
=========================================

Name: stump_memory_responder

Overview:
- Memory-side responder for Stump datapath bus transactions: answers each read/write request after a programmable number of wait states.
- Holds a word-addressed 16-bit RAM and a small memory-mapped I/O page: LED output register, synchronised switch input, free-running cycle counter.
- Sits between the Stump control/datapath pair and the board I/O.
- The Stump holds its request until it sees rdy.

Parameters:
ADDR_W, 8, RAM address width; RAM depth 2**ADDR_W words at 0x0000..(2**ADDR_W)-1
WAIT_STATES, 1, extra cycles between request accept and response (0..15)
IO_BASE, 16'hFF00, base of 4-word I/O page

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
req  input  1  request valid, held by requester until rdy
we  input  1  1 = write, 0 = read; qualified by req
addr  input  16  word address
wdata  input  16  write data
rdata  output  16  read data, valid while rdy=1
rdy  output  1  one-cycle response strobe
busy  output  1  high when not in IDLE
err  output  1  with rdy: access hit an unmapped address
sw_in  input  16  asynchronous switch inputs
led_out  output  16  LED output register

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM to IDLE; rdy, err, busy = 0; rdata = 0.
  - led_out = 0; cycle counter = 0; switch synchronisers = 0.
  - A pending write is discarded.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req sampled only here.
  - On req=1, latch addr/we/wdata and load wait counter with WAIT_STATES.
  - Next state is WAIT, or RESP directly if WAIT_STATES=0.
- WAIT:
  - Counter decrements each cycle.
  - When counter=1, next state is RESP.
  - req changes are ignored.
- Commit on the edge entering RESP:
  - Read: rdata is registered from the decoded source.
  - Write: the target is updated.
- RESP:
  - rdy=1 for exactly one cycle; next state is IDLE.
  - Latency is WAIT_STATES+1 cycles from the accepting edge to rdy high.
  - Requester drops req in the cycle after rdy. A req still high in IDLE starts a new transaction (back-to-back allowed, min 2 cycles/access with WAIT_STATES=0).
- busy=1 in WAIT and RESP.
- Address decode on latched addr:
  - addr < 2**ADDR_W: RAM, index addr[ADDR_W-1:0].
  - IO_BASE+0: LED register, R/W.
  - IO_BASE+1: switches, RO, two-flop synchronised sw_in; writes ignored.
  - IO_BASE+2: cycle counter, R/W.
  - IO_BASE+3: status RO = {12'b0, WAIT_STATES[3:0]}; writes ignored.
  - Anything else is unmapped: read returns 16'h0000, write has no effect, err=1 alongside rdy.
- err is 0 whenever rdy is 0.
- Cycle counter:
  - Increments every clock, 16'hFFFF wraps to 0.
  - On a write commit to IO_BASE+2 the counter loads wdata; the write wins over the increment.
  - Reads return the value at the commit edge (pre-increment).
- rdata holds its last value between responses.
- Reset asserted mid-transaction: no rdy is generated for that transaction; FSM restarts in IDLE after reset release.

Test Plan:
- WAIT_STATES=1: write 16'hBEEF to 0x0010 (req on cycle 0) -> rdy high cycle 2, err=0. Read 0x0010 -> rdy 2 cycles later with rdata=16'hBEEF.
- WAIT_STATES=0: back-to-back with req held high: write 0x0001=16'h1234, then read 0x0001 -> each rdy 1 cycle after accept, rdy every 2nd cycle, read returns 16'h1234.
- I/O page:
  - Write IO_BASE+0=16'h00A5 -> led_out=16'h00A5 from the RESP cycle.
  - With sw_in=16'h5A5A stable 3+ cycles, read IO_BASE+1 -> 16'h5A5A.
  - Read IO_BASE+3 -> 16'h0001.
- Counter: write IO_BASE+2=16'hFFFE, wait 3 cycles, read -> value = 16'hFFFE + elapsed cycles mod 2^16 (wraps through 0). Write and increment on the same edge -> loaded value wins.
- Unmapped: read 0x8000 -> rdy with err=1, rdata=0. Write 0x8000=16'h1111 then read 0x0000 -> RAM unchanged.
- Reset mid-WAIT with WAIT_STATES=3 during a write to led_out -> no rdy, busy=0, led_out=0. Next request completes normally.

Source files
------------

// File: rtl/stump_memory_responder.sv
// rtl/stump_memory_responder.sv - Stump bus memory responder: wait-stated RAM plus a 4-word I/O page
module stump_memory_responder #(
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_STATES = 1,
    parameter logic [15:0] IO_BASE     = 16'hFF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        rdy,
    output logic        busy,
    output logic        err,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam int         DEPTH  = 1 << ADDR_W;
    localparam logic [3:0] WS4    = 4'(WAIT_STATES);

    logic [1:0]  state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [15:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [15:0] led_q, led_d;
    logic [15:0] cyc_q, cyc_d;
    logic [15:0] sw_meta_q, sw_sync_q;
    logic [15:0] mem [DEPTH];

    logic              commit;
    logic [15:0]       c_addr, c_wdata;
    logic              c_we;
    logic              hit_ram, mapped;
    logic [ADDR_W-1:0] ram_idx;
    logic [15:0]       rd_val;

    // With zero wait states the commit happens on the accepting edge, so the
    // live request fields are used instead of the latched copies.
    always_comb begin
        commit  = ((state_q == S_IDLE) && req && (WAIT_STATES == 0))
               || ((state_q == S_WAIT) && (wcnt_q == 4'd1));
        c_addr  = (state_q == S_IDLE) ? addr  : addr_q;
        c_we    = (state_q == S_IDLE) ? we    : we_q;
        c_wdata = (state_q == S_IDLE) ? wdata : wdata_q;
        hit_ram = (c_addr >> ADDR_W) == 16'd0;
        ram_idx = c_addr[ADDR_W-1:0];
    end

    always_comb begin
        rd_val = 16'd0;
        mapped = 1'b1;
        if (hit_ram)                         rd_val = mem[ram_idx];
        else if (c_addr == IO_BASE)          rd_val = led_q;
        else if (c_addr == IO_BASE + 16'd1)  rd_val = sw_sync_q;
        else if (c_addr == IO_BASE + 16'd2)  rd_val = cyc_q;
        else if (c_addr == IO_BASE + 16'd3)  rd_val = {12'd0, WS4};
        else                                 mapped = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        led_d   = led_q;
        cyc_d   = cyc_q + 16'd1;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    we_d    = we;
                    wdata_d = wdata;
                    wcnt_d  = WS4;
                    state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                wcnt_d = wcnt_q - 4'd1;
                if (wcnt_q == 4'd1) state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (commit) begin
            err_d = ~mapped;
            if (c_we) begin
                if (c_addr == IO_BASE)         led_d = c_wdata;
                if (c_addr == IO_BASE + 16'd2) cyc_d = c_wdata;
            end else begin
                rdata_d = rd_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            wcnt_q    <= 4'd0;
            addr_q    <= 16'd0;
            we_q      <= 1'b0;
            wdata_q   <= 16'd0;
            rdata_q   <= 16'd0;
            err_q     <= 1'b0;
            led_q     <= 16'd0;
            cyc_q     <= 16'd0;
            sw_meta_q <= 16'd0;
            sw_sync_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            led_q     <= led_d;
            cyc_q     <= cyc_d;
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
        end
    end

    // RAM has no reset; gating on rst keeps a write from landing while reset is held.
    always_ff @(posedge clk) begin
        if (rst && commit && c_we && hit_ram) mem[ram_idx] <= c_wdata;
    end

    assign rdy     = (state_q == S_RESP);
    assign busy    = (state_q != S_IDLE);
    assign err     = rdy & err_q;
    assign rdata   = rdata_q;
    assign led_out = led_q;

endmodule

// File: tb/tb_stump_memory_responder.sv
// tb/tb_stump_memory_responder.sv - directed vector bench for stump_memory_responder
module tb_stump_memory_responder;

    logic        clk = 1'b0;
    logic        rst_n  [3];
    logic        req    [3];
    logic        we     [3];
    logic [15:0] addr   [3];
    logic [15:0] wdata  [3];
    logic [15:0] rdata  [3];
    logic        rdy    [3];
    logic        busy   [3];
    logic        err    [3];
    logic [15:0] sw_in  [3];
    logic [15:0] led    [3];

    int ws_of [3] = '{1, 0, 3};
    int n_cmp  = 0;
    int n_fail = 0;
    int tb_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    stump_memory_responder #(.ADDR_W(8), .WAIT_STATES(1), .IO_BASE(16'hFF00)) u_ws1 (
        .clk(clk), .rst(rst_n[0]), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
        .rdata(rdata[0]), .rdy(rdy[0]), .busy(busy[0]), .err(err[0]), .sw_in(sw_in[0]), .led_out(led[0]));
    stump_memory_responder #(.ADDR_W(8), .WAIT_STATES(0), .IO_BASE(16'hFF00)) u_ws0 (
        .clk(clk), .rst(rst_n[1]), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
        .rdata(rdata[1]), .rdy(rdy[1]), .busy(busy[1]), .err(err[1]), .sw_in(sw_in[1]), .led_out(led[1]));
    stump_memory_responder #(.ADDR_W(8), .WAIT_STATES(3), .IO_BASE(16'hFF00)) u_ws3 (
        .clk(clk), .rst(rst_n[2]), .req(req[2]), .we(we[2]), .addr(addr[2]), .wdata(wdata[2]),
        .rdata(rdata[2]), .rdy(rdy[2]), .busy(busy[2]), .err(err[2]), .sw_in(sw_in[2]), .led_out(led[2]));

    typedef struct {
        int          k;
        logic        w;
        logic [15:0] a;
        logic [15:0] d;
        logic        chk_rd;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int k, logic w, logic [15:0] a, logic [15:0] d,
                                logic chk_rd, logic [15:0] exp_rd, logic exp_err);
        vec_t v;
        v.k = k; v.w = w; v.a = a; v.d = d;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [15:0] last_rd, last_led;
    logic        last_err;
    int          last_lat, last_edge;

    // Present one request, wait for rdy, record what came back.
    task automatic access(input int k, input logic w, input logic [15:0] a, input logic [15:0] d);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 20 && busy[k]; i++) @(negedge clk);
        req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
        last_lat = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            last_lat++;
            if (rdy[k]) seen = 1'b1;
        end
        chk("rdy_seen", {15'd0, seen}, 16'd1);
        last_rd   = rdata[k];
        last_err  = err[k];
        last_led  = led[k];
        last_edge = tb_cyc;
        req[k] = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_cnt;
        int e_w;
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; req[k] = 1'b0; we[k] = 1'b0;
            addr[k] = 16'd0; wdata[k] = 16'd0; sw_in[k] = 16'd0;
        end
        sw_in[0] = 16'h5A5A;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 3; k++) begin
            chk("reset_rdy",   {15'd0, rdy[k]},  16'd0);
            chk("reset_busy",  {15'd0, busy[k]}, 16'd0);
            chk("reset_err",   {15'd0, err[k]},  16'd0);
            chk("reset_rdata", rdata[k], 16'd0);
            chk("reset_led",   led[k],   16'd0);
        end

        vecs.push_back(mk(0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, 1'b0));
        vecs.push_back(mk(0, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'hBEEF, 1'b0));
        vecs.push_back(mk(0, 1'b1, 16'hFF00, 16'h00A5, 1'b0, 16'h0000, 1'b0));
        vecs.push_back(mk(0, 1'b0, 16'hFF01, 16'h0000, 1'b1, 16'h5A5A, 1'b0));
        vecs.push_back(mk(0, 1'b0, 16'hFF03, 16'h0000, 1'b1, 16'h0001, 1'b0));
        vecs.push_back(mk(0, 1'b0, 16'h8000, 16'h0000, 1'b1, 16'h0000, 1'b1));
        vecs.push_back(mk(0, 1'b1, 16'h0000, 16'hCAFE, 1'b0, 16'h0000, 1'b0));
        vecs.push_back(mk(0, 1'b1, 16'h8000, 16'h1111, 1'b0, 16'h0000, 1'b1));
        vecs.push_back(mk(0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hCAFE, 1'b0));
        vecs.push_back(mk(0, 1'b0, 16'hFF00, 16'h0000, 1'b1, 16'h00A5, 1'b0));
        vecs.push_back(mk(0, 1'b1, 16'hFF01, 16'hFFFF, 1'b0, 16'h0000, 1'b0));
        vecs.push_back(mk(0, 1'b0, 16'hFF01, 16'h0000, 1'b1, 16'h5A5A, 1'b0));
        vecs.push_back(mk(0, 1'b1, 16'hFF03, 16'h7777, 1'b0, 16'h0000, 1'b0));
        vecs.push_back(mk(0, 1'b0, 16'hFF03, 16'h0000, 1'b1, 16'h0001, 1'b0));
        vecs.push_back(mk(0, 1'b0, 16'hFF04, 16'h0000, 1'b1, 16'h0000, 1'b1));
        vecs.push_back(mk(0, 1'b1, 16'h00FF, 16'h7E57, 1'b0, 16'h0000, 1'b0));
        vecs.push_back(mk(0, 1'b0, 16'h00FF, 16'h0000, 1'b1, 16'h7E57, 1'b0));
        vecs.push_back(mk(0, 1'b0, 16'h0100, 16'h0000, 1'b1, 16'h0000, 1'b1));
        vecs.push_back(mk(2, 1'b1, 16'h0020, 16'h1357, 1'b0, 16'h0000, 1'b0));
        vecs.push_back(mk(2, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'h1357, 1'b0));
        vecs.push_back(mk(2, 1'b0, 16'hFF03, 16'h0000, 1'b1, 16'h0003, 1'b0));
        vecs.push_back(mk(1, 1'b0, 16'hFF03, 16'h0000, 1'b1, 16'h0000, 1'b0));

        foreach (vecs[i]) begin
            access(vecs[i].k, vecs[i].w, vecs[i].a, vecs[i].d);
            chk($sformatf("v%0d_latency", i), 16'(last_lat), 16'(ws_of[vecs[i].k] + 1));
            chk($sformatf("v%0d_err", i), {15'd0, last_err}, {15'd0, vecs[i].exp_err});
            if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), last_rd, vecs[i].exp_rd);
            if (vecs[i].w && vecs[i].a == 16'hFF00)
                chk($sformatf("v%0d_led", i), last_led, vecs[i].d);
        end

        // Counter: loaded value wins over increment, then counts through the wrap.
        access(0, 1'b1, 16'hFF02, 16'hFFFE);
        e_w = last_edge;
        repeat (3) @(posedge clk);
        access(0, 1'b0, 16'hFF02, 16'h0000);
        exp_cnt = 16'hFFFE + 16'(last_edge - e_w - 1);
        chk("cnt_wrap_read", last_rd, exp_cnt);
        chk("cnt_wrapped", {15'd0, (last_rd < 16'hFFFE)}, 16'd1);

        // Back-to-back with req held high, zero wait states.
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 16'h0001; wdata[1] = 16'h1234;
        @(posedge clk); #1;
        chk("b2b_wr_rdy", {15'd0, rdy[1]}, 16'd1);
        chk("b2b_wr_err", {15'd0, err[1]}, 16'd0);
        we[1] = 1'b0;
        @(posedge clk); #1;
        chk("b2b_gap_rdy", {15'd0, rdy[1]}, 16'd0);
        @(posedge clk); #1;
        chk("b2b_rd_rdy", {15'd0, rdy[1]}, 16'd1);
        chk("b2b_rd_data", rdata[1], 16'h1234);
        req[1] = 1'b0;
        @(posedge clk); #1;
        chk("b2b_end_rdy", {15'd0, rdy[1]}, 16'd0);
        chk("b2b_end_busy", {15'd0, busy[1]}, 16'd0);

        // Reset during WAIT of a LED write on the 3-wait-state instance.
        @(negedge clk);
        req[2] = 1'b1; we[2] = 1'b1; addr[2] = 16'hFF00; wdata[2] = 16'h00C3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_pre_busy", {15'd0, busy[2]}, 16'd1);
        @(negedge clk);
        rst_n[2] = 1'b0; req[2] = 1'b0;
        #1;
        chk("rst_busy", {15'd0, busy[2]}, 16'd0);
        chk("rst_rdy",  {15'd0, rdy[2]},  16'd0);
        chk("rst_led",  led[2], 16'd0);
        chk("rst_rdata", rdata[2], 16'd0);
        repeat (2) @(negedge clk);
        rst_n[2] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("rst_no_rdy", {15'd0, rdy[2]}, 16'd0);
        end
        chk("rst_led_after", led[2], 16'd0);
        access(2, 1'b1, 16'hFF00, 16'h0042);
        chk("rst_next_latency", 16'(last_lat), 16'd4);
        chk("rst_next_led", last_led, 16'h0042);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
